// File: rtl/carrier_gen_multi_if.sv
// carrier_gen_multi_if
// Bus bundle for the multi-channel PWM carrier generator.
//   enable      run/stop request
//   count_mode  00 none, 01 up, 10 down, 11 up-down (shadow value)
//   period      carrier peak value P (shadow value)
//   init_carr   per-channel start phase, channel i at [i*WIDTH +: WIDTH]
//   load        one-cycle resynchronise request
//   carrier     registered carrier values, packed like init_carr
//   zero_evt    per-channel pulse, counting step produced 0
//   peak_evt    per-channel pulse, counting step produced the active P
//   sync_evt    channel 0 cycle boundary, active registers committed
// The master modport drives the controls, the slave modport is the generator.
interface carrier_gen_multi_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  logic                   enable;
  logic [1:0]             count_mode;
  logic [WIDTH-1:0]       period;
  logic [NCH*WIDTH-1:0]   init_carr;
  logic                   load;
  logic [NCH*WIDTH-1:0]   carrier;
  logic [NCH-1:0]         zero_evt;
  logic [NCH-1:0]         peak_evt;
  logic                   sync_evt;

  modport master (
    output enable, count_mode, period, init_carr, load,
    input  carrier, zero_evt, peak_evt, sync_evt
  );

  modport slave (
    input  enable, count_mode, period, init_carr, load,
    output carrier, zero_evt, peak_evt, sync_evt
  );
endinterface

// File: rtl/carrier_gen_multi.sv
// carrier_gen_multi
// NCH carrier counters of WIDTH bits sharing one period and count mode, each
// with its own start phase. Period and mode pass through active registers
// that are refreshed only at a channel 0 cycle boundary (or on start/load),
// so a carrier never changes shape mid-cycle.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    carrier_gen_multi_if.slave (controls in, carriers and events out)
module carrier_gen_multi #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input logic             clk,
  input logic             reset,
  carrier_gen_multi_if.slave bus
);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  typedef enum logic [1:0] {
    NO_COUNT     = 2'b00,
    COUNT_UP     = 2'b01,
    COUNT_DOWN   = 2'b10,
    COUNT_UPDOWN = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t            state_q, state_d;
  mode_t             act_mode_q, act_mode_d;
  mode_t             in_mode;
  logic [WIDTH-1:0]  act_period_q, act_period_d;
  logic [WIDTH-1:0]  next_period;

  logic [WIDTH-1:0]  carr_q   [NCH];
  logic [WIDTH-1:0]  carr_d   [NCH];
  logic [WIDTH-1:0]  init_val [NCH];
  logic [WIDTH-1:0]  step_val [NCH];

  // Direction bits: 0 = UP, 1 = DOWN (only meaningful in up-down mode)
  logic [NCH-1:0]    dir_q, dir_d;
  logic [NCH-1:0]    init_dir;
  logic [NCH-1:0]    step_dir;
  logic [NCH-1:0]    step_clamp;

  logic [NCH-1:0]    zero_q, zero_d;
  logic [NCH-1:0]    peak_q, peak_d;
  logic              sync_q, sync_d;

  logic              run_ok;
  logic              boundary;
  logic              mode_change;

  assign in_mode = mode_t'(bus.count_mode);

  // Run conditions are live inputs, never shadowed.
  assign run_ok = bus.enable && (bus.count_mode != 2'b00) && (bus.period != '0);

  // Channel 0 boundary: the edge on which channel 0 wraps (up/down) or
  // arrives at zero from one (up-down). Up-down with P = 1 goes 1 -> 0 while
  // still flagged UP, hence the extra period test.
  always_comb begin
    boundary = 1'b0;
    if (state_q == ST_RUN) begin
      case (act_mode_q)
        COUNT_UP:     boundary = (carr_q[0] == act_period_q);
        COUNT_DOWN:   boundary = (carr_q[0] == '0);
        COUNT_UPDOWN: boundary = (carr_q[0] == ONE) &&
                                 (dir_q[0] || (act_period_q == ONE));
        default:      boundary = 1'b0;
      endcase
    end
  end

  // A boundary commits the shadow period, and that new period is already the
  // reload target for a down-count wrap on the same edge.
  assign next_period = boundary ? bus.period : act_period_q;
  assign mode_change = boundary && (in_mode != act_mode_q);

  // Start/load targets: phase clamped to the new period; up-down channels
  // that start at the peak must head down.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      init_val[i] = (bus.init_carr[i*WIDTH +: WIDTH] > bus.period) ?
                    bus.period : bus.init_carr[i*WIDTH +: WIDTH];
      init_dir[i] = (in_mode == COUNT_UPDOWN) && (init_val[i] == bus.period);
    end
  end

  // One counting step per channel under the active mode/period. A value
  // above the active period only exists right after a period shrink; it is
  // pulled to P without being treated as a real step (no events).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      step_val[i]   = carr_q[i];
      step_dir[i]   = dir_q[i];
      step_clamp[i] = 1'b0;
      if (carr_q[i] > act_period_q) begin
        step_val[i]   = act_period_q;
        step_dir[i]   = 1'b1;
        step_clamp[i] = 1'b1;
      end else begin
        case (act_mode_q)
          COUNT_UP: begin
            step_val[i] = (carr_q[i] == act_period_q) ? '0 : carr_q[i] + ONE;
          end
          COUNT_DOWN: begin
            step_val[i] = (carr_q[i] == '0) ? next_period : carr_q[i] - ONE;
          end
          COUNT_UPDOWN: begin
            if (!dir_q[i]) begin
              if (carr_q[i] == act_period_q) begin
                step_val[i] = carr_q[i] - ONE;
                step_dir[i] = 1'b1;
              end else begin
                step_val[i] = carr_q[i] + ONE;
              end
            end else begin
              if (carr_q[i] == '0) begin
                step_val[i] = ONE;
                step_dir[i] = 1'b0;
              end else begin
                step_val[i] = carr_q[i] - ONE;
              end
            end
          end
          default: step_val[i] = carr_q[i];
        endcase
      end
      if (mode_change) begin
        step_dir[i] = (in_mode == COUNT_UPDOWN) && (step_val[i] == bus.period);
      end
    end
  end

  // Top-level next state. Priority: stop > load > boundary commit > count.
  // A load on a boundary edge still reports the boundary through sync_evt.
  always_comb begin
    state_d      = state_q;
    act_period_d = act_period_q;
    act_mode_d   = act_mode_q;
    carr_d       = carr_q;
    dir_d        = dir_q;
    zero_d       = '0;
    peak_d       = '0;
    sync_d       = 1'b0;
    case (state_q)
      ST_STOP: begin
        for (int i = 0; i < NCH; i++) carr_d[i] = '0;
        dir_d = '0;
        if (run_ok) begin
          state_d      = ST_RUN;
          act_period_d = bus.period;
          act_mode_d   = in_mode;
          carr_d       = init_val;
          dir_d        = init_dir;
        end
      end
      ST_RUN: begin
        if (!run_ok) begin
          state_d = ST_STOP;
          for (int i = 0; i < NCH; i++) carr_d[i] = '0;
          dir_d = '0;
        end else if (bus.load) begin
          act_period_d = bus.period;
          act_mode_d   = in_mode;
          carr_d       = init_val;
          dir_d        = init_dir;
          sync_d       = boundary;
        end else begin
          carr_d = step_val;
          dir_d  = step_dir;
          for (int i = 0; i < NCH; i++) begin
            zero_d[i] = !step_clamp[i] && (step_val[i] == '0);
            peak_d[i] = !step_clamp[i] && (step_val[i] == next_period);
          end
          if (boundary) begin
            act_period_d = bus.period;
            act_mode_d   = in_mode;
            sync_d       = 1'b1;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_STOP;
      act_period_q <= '0;
      act_mode_q   <= NO_COUNT;
      for (int i = 0; i < NCH; i++) carr_q[i] <= '0;
      dir_q        <= '0;
      zero_q       <= '0;
      peak_q       <= '0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_period_q <= act_period_d;
      act_mode_q   <= act_mode_d;
      carr_q       <= carr_d;
      dir_q        <= dir_d;
      zero_q       <= zero_d;
      peak_q       <= peak_d;
      sync_q       <= sync_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign bus.carrier[g*WIDTH +: WIDTH] = carr_q[g];
  end

  assign bus.zero_evt = zero_q;
  assign bus.peak_evt = peak_q;
  assign bus.sync_evt = sync_q;

endmodule
